// File: rtl/radar_pkg.sv
// Shared radar pipeline definitions: magnitude word width, frame depth and
// the serializer state encoding.
package radar_pkg;

  localparam int unsigned MAG_W       = 12;
  localparam int unsigned FRAME_DEPTH = 2048;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ARM     = 2'd2,
    SHIFT   = 2'd3
  } ser_state_t;

endpackage

// File: rtl/mag_frame_ram.sv
// Frame buffer: DEPTH x DATA_W, split into even/odd banks by addr[0] so one
// even-index and one odd-index word can be written per cycle. Single read
// port with one cycle of latency. Contents are never reset.
module mag_frame_ram
  import radar_pkg::*;
#(
  parameter int unsigned DATA_W = MAG_W,
  parameter int unsigned DEPTH  = FRAME_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic [$clog2(DEPTH)-1:0] wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned BANK_D = DEPTH / 2;

  logic [DATA_W-1:0] even_mem [BANK_D];
  logic [DATA_W-1:0] odd_mem  [BANK_D];

  // Even bank takes whichever write port targets an even address
  always_ff @(posedge clk) begin
    if (wr_en && !wr_addr0[0]) begin
      even_mem[wr_addr0[AW-1:1]] <= wr_data0;
    end else if (wr_en && !wr_addr1[0]) begin
      even_mem[wr_addr1[AW-1:1]] <= wr_data1;
    end
  end

  // Odd bank takes whichever write port targets an odd address
  always_ff @(posedge clk) begin
    if (wr_en && wr_addr1[0]) begin
      odd_mem[wr_addr1[AW-1:1]] <= wr_data1;
    end else if (wr_en && wr_addr0[0]) begin
      odd_mem[wr_addr0[AW-1:1]] <= wr_data0;
    end
  end

  // Registered read, bank selected by the low address bit
  always_ff @(posedge clk) begin
    rd_data <= rd_addr[0] ? odd_mem[rd_addr[AW-1:1]] : even_mem[rd_addr[AW-1:1]];
  end

endmodule

// File: rtl/mag_serializer.sv
// Captures a frame of FFT magnitudes (two words per clock) into a frame
// buffer, then shifts it out MSB-first on a single wire, one bit per
// clk_div_16 period, changing data on the serial clock's falling edge.
// Optional build macro MAG_SERIALIZER_PARITY_EN appends an even-parity bit
// after every word.
module mag_serializer
  import radar_pkg::*;
#(
  parameter int unsigned DATA_W  = MAG_W,
  parameter int unsigned DEPTH   = FRAME_DEPTH,
  parameter int unsigned CLK_DIV = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fft_next_out,
  input  logic              mag_valid,
  input  logic [DATA_W-1:0] mag_out1,
  input  logic [DATA_W-1:0] mag_out2,
  output logic              clk_div_16,
  output logic              data,
  output logic              next_data,
  output logic              busy,
  output logic              frame_drop
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(CLK_DIV);
  localparam int unsigned HALF = CLK_DIV / 2;
`ifdef MAG_SERIALIZER_PARITY_EN
  localparam int unsigned WORD_BITS = DATA_W + 1;
`else
  localparam int unsigned WORD_BITS = DATA_W;
`endif
  localparam int unsigned BW = $clog2(WORD_BITS);

  ser_state_t state, state_n;

  logic [CW-1:0]          div_cnt, div_cnt_n;
  logic                   clk_div_n;
  logic                   fall_c;
  logic [AW-1:0]          wp, wp_n;
  logic [AW-1:0]          word_idx, word_idx_n;
  logic [BW-1:0]          bit_cnt, bit_cnt_n;
  logic [WORD_BITS-2:0]   rest_bits, rest_bits_n;
  logic                   arm_first, arm_first_n;
  logic                   data_n, next_data_n, busy_n, frame_drop_n;
  logic                   wr_en_c;
  logic [AW-1:0]          rd_addr_c;
  logic [DATA_W-1:0]      rd_data;
  logic [WORD_BITS-1:0]   load_word_c;

  // Word as it goes on the wire, MSB first
`ifdef MAG_SERIALIZER_PARITY_EN
  assign load_word_c = {rd_data, ^rd_data};
`else
  assign load_word_c = rd_data;
`endif

  // Serial clock divider: clk_div_16 is high for the upper half of the count
  always_comb begin
    fall_c    = (div_cnt == CW'(CLK_DIV - 1));
    div_cnt_n = fall_c ? '0 : div_cnt + CW'(1);
    clk_div_n = (div_cnt_n >= CW'(HALF));
  end

  mag_frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_en_c),
    .wr_addr0 (wp),
    .wr_data0 (mag_out1),
    .wr_addr1 ({wp[AW-1:1], 1'b1}),
    .wr_data1 (mag_out2),
    .rd_addr  (rd_addr_c),
    .rd_data  (rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_n      = state;
    wp_n         = wp;
    word_idx_n   = word_idx;
    bit_cnt_n    = bit_cnt;
    rest_bits_n  = rest_bits;
    arm_first_n  = 1'b0;
    data_n       = data;
    next_data_n  = next_data;
    wr_en_c      = 1'b0;
    rd_addr_c    = word_idx + AW'(1);

    case (state)
      IDLE: begin
        if (fft_next_out) begin
          state_n = CAPTURE;
          wp_n    = '0;
        end
      end
      CAPTURE: begin
        if (mag_valid) begin
          wr_en_c = 1'b1;
          if (wp == AW'(DEPTH - 2)) begin
            state_n     = ARM;
            arm_first_n = 1'b1;
          end else begin
            wp_n = wp + AW'(2);
          end
        end
      end
      ARM: begin
        // Word 0 read is issued here; skip a fall tick that comes too soon
        rd_addr_c = '0;
        if (fall_c && !arm_first) begin
          state_n     = SHIFT;
          word_idx_n  = '0;
          bit_cnt_n   = '0;
          data_n      = load_word_c[WORD_BITS-1];
          rest_bits_n = load_word_c[WORD_BITS-2:0];
          next_data_n = 1'b1;
        end
      end
      SHIFT: begin
        if (fall_c) begin
          next_data_n = 1'b0;
          if (bit_cnt == BW'(WORD_BITS - 1)) begin
            if (word_idx == AW'(DEPTH - 1)) begin
              state_n = IDLE;
              data_n  = 1'b0;
            end else begin
              // rd_data already holds the prefetched next word
              word_idx_n  = word_idx + AW'(1);
              bit_cnt_n   = '0;
              data_n      = load_word_c[WORD_BITS-1];
              rest_bits_n = load_word_c[WORD_BITS-2:0];
            end
          end else begin
            bit_cnt_n   = bit_cnt + BW'(1);
            data_n      = rest_bits[WORD_BITS-2];
            rest_bits_n = {rest_bits[WORD_BITS-3:0], 1'b0};
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n       = (state_n != IDLE);
    frame_drop_n = fft_next_out && (state != IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      clk_div_16 <= 1'b0;
      wp         <= '0;
      word_idx   <= '0;
      bit_cnt    <= '0;
      rest_bits  <= '0;
      arm_first  <= 1'b0;
      data       <= 1'b0;
      next_data  <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_n;
      clk_div_16 <= clk_div_n;
      wp         <= wp_n;
      word_idx   <= word_idx_n;
      bit_cnt    <= bit_cnt_n;
      rest_bits  <= rest_bits_n;
      arm_first  <= arm_first_n;
      data       <= data_n;
      next_data  <= next_data_n;
      busy       <= busy_n;
      frame_drop <= frame_drop_n;
    end
  end

endmodule

// File: tb/tb_mag_serializer.sv
// Bench for mag_serializer with an 8-word frame. Expected serial bits come
// from a queue built directly from the frame words (MSB first, optional
// even parity under MAG_SERIALIZER_PARITY_EN).
module tb_mag_serializer;

  localparam int unsigned DW      = 12;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CLK_DIV = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fft_next_out;
  logic          mag_valid;
  logic [DW-1:0] mag_out1;
  logic [DW-1:0] mag_out2;
  logic          clk_div_16;
  logic          data;
  logic          next_data;
  logic          busy;
  logic          frame_drop;

  int n_assert = 0;
  int n_fail   = 0;
  bit div_prev = 1'b0;
  bit div_rise = 1'b0;

  logic [DW-1:0] words [DEPTH];

  mag_serializer #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fft_next_out (fft_next_out),
    .mag_valid    (mag_valid),
    .mag_out1     (mag_out1),
    .mag_out2     (mag_out2),
    .clk_div_16   (clk_div_16),
    .data         (data),
    .next_data    (next_data),
    .busy         (busy),
    .frame_drop   (frame_drop)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample on the falling edge and track serial-clock rises
  task automatic step();
    @(negedge clk);
    div_rise = (clk_div_16 === 1'b1) && !div_prev;
    div_prev = (clk_div_16 === 1'b1);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic noise();
    mag_valid = 1'($urandom);
    mag_out1  = DW'($urandom);
    mag_out2  = DW'($urandom);
  endtask

  // One frame: capture, serial readout against the bit queue, end-of-frame
  task automatic run_frame(input int gap, input bit drop_cap, input int drop_bit,
                           input int rst_bit, input bit collide);
    bit exp_q[$];
    int lat;
    int n;
    int nd_cyc;
    bit ok;

    exp_q = {};
    for (int k = 0; k < int'(DEPTH); k++) begin
      for (int b = int'(DW) - 1; b >= 0; b--) exp_q.push_back(words[k][b]);
`ifdef MAG_SERIALIZER_PARITY_EN
      exp_q.push_back(^words[k]);
`endif
    end

    chk1("busy_idle", busy, 1'b0);
    mag_valid = 1'b0;
    fft_next_out = 1'b1;
    step();
    fft_next_out = 1'b0;
    chk1("busy_rise", busy, 1'b1);

    for (int k = 0; k < int'(DEPTH) / 2; k++) begin
      for (int g = 0; g < gap; g++) begin
        mag_valid = 1'b0;
        mag_out1  = DW'($urandom);
        mag_out2  = DW'($urandom);
        step();
      end
      mag_valid = 1'b1;
      mag_out1  = words[2*k];
      mag_out2  = words[2*k+1];
      if (drop_cap && k == 1) fft_next_out = 1'b1;
      step();
      if (drop_cap && k == 1) begin
        fft_next_out = 1'b0;
        chk1("drop_capture", frame_drop, 1'b1);
      end
      mag_valid = 1'b0;
    end

    lat = 0;
    while (next_data !== 1'b1 && lat < int'(CLK_DIV) + 8) begin
      noise();
      step();
      lat++;
    end
    chk1("latency_window", (lat >= 2 && lat <= int'(CLK_DIV) + 2), 1'b1);
    if (next_data !== 1'b1) return;

    nd_cyc = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      n = 0;
      do begin
        noise();
        step();
        n++;
        if (next_data === 1'b1) nd_cyc++;
      end while (!div_rise && n < int'(CLK_DIV) + 2);
      if (!div_rise) begin
        chk1("rise_timeout", 1'b0, 1'b1);
        return;
      end
      chk1($sformatf("bit%0d", i), data, exp_q[i]);
      chk1($sformatf("next_data%0d", i), next_data, (i == 0));
      chk1("busy_shift", busy, 1'b1);
      if (i == drop_bit) begin
        fft_next_out = 1'b1;
        step();
        fft_next_out = 1'b0;
        chk1("drop_shift", frame_drop, 1'b1);
        if (next_data === 1'b1) nd_cyc++;
      end
      if (i == rst_bit) begin
        reset_n = 1'b0;
        step();
        chk1("rst_data", data, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_next_data", next_data, 1'b0);
        chk1("rst_clk_div", clk_div_16, 1'b0);
        chk1("rst_frame_drop", frame_drop, 1'b0);
        repeat (3) step();
        reset_n = 1'b1;
        return;
      end
    end
    chki("next_data_width", nd_cyc, int'(CLK_DIV));

    if (collide) begin
      repeat (CLK_DIV / 2 - 1) step();
      fft_next_out = 1'b1;
      step();
      fft_next_out = 1'b0;
      chk1("collide_busy", busy, 1'b0);
      chk1("collide_drop", frame_drop, 1'b1);
      chk1("end_data", data, 1'b0);
      step();
      chk1("collide_drop_clear", frame_drop, 1'b0);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < int'(CLK_DIV)) begin
        step();
        n++;
      end
      chki("busy_fall_delay", n, int'(CLK_DIV) / 2);
      chk1("end_data", data, 1'b0);
    end

    ok = 1'b1;
    repeat (2 * CLK_DIV) begin
      noise();
      step();
      if (busy !== 1'b0 || next_data !== 1'b0) ok = 1'b0;
    end
    chk1("stay_idle", ok, 1'b1);
    mag_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    fft_next_out = 1'b0;
    mag_valid    = 1'b0;
    mag_out1     = '0;
    mag_out2     = '0;

    repeat (5) step();
    chk1("reset_clk_div", clk_div_16, 1'b0);
    chk1("reset_data", data, 1'b0);
    chk1("reset_next_data", next_data, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_frame_drop", frame_drop, 1'b0);

    reset_n = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!div_rise && n < 2 * int'(CLK_DIV));
    chki("first_rise_delay", n, int'(CLK_DIV) / 2);

    // Directed frame, contiguous pairs
    words[0] = 12'hA5C; words[1] = 12'h3F1;
    words[2] = 12'h000; words[3] = 12'hFFF;
    words[4] = 12'h800; words[5] = 12'h001;
    words[6] = 12'h123; words[7] = 12'h456;
    run_frame(0, 1'b0, -1, -1, 1'b0);

    // Same frame, one valid pair every third cycle
    run_frame(2, 1'b0, -1, -1, 1'b0);

    // Random frame with ignored frame starts during capture and shift
    foreach (words[k]) words[k] = DW'($urandom);
    run_frame(int'($urandom_range(0, 3)), 1'b1, 20, -1, 1'b0);

    // Random frame aborted by reset at bit 40
    foreach (words[k]) words[k] = DW'($urandom);
    run_frame(0, 1'b0, -1, 40, 1'b0);

    // Full frame after the reset, frame start colliding with the last tick
    foreach (words[k]) words[k] = DW'($urandom);
    run_frame(1, 1'b0, -1, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
